// File: rtl/pdp_mem_responder.sv
// pdp_mem_responder: 4K x 12 PDP-8 main store with one shared array port.
// The array port is arbitrated each cycle in this order: preload, exec write,
// exec read, instruction fetch. A fetch that loses arbitration is retried
// every cycle until it wins. proto_err records illegal request combinations
// and stays set until reset. The array itself has no reset.
module pdp_mem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12,
    parameter int MEM_DEPTH  = 4096
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  exec_rd_req,
    input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
    output logic [DATA_WIDTH-1:0] exec_rd_data,
    input  logic                  exec_wr_req,
    input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
    input  logic [DATA_WIDTH-1:0] exec_wr_data,
    input  logic                  ifu_rd_req,
    input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    output logic [DATA_WIDTH-1:0] ifu_rd_data,
    output logic                  ifu_rd_valid,
    input  logic                  ld_en,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  proto_err
);

    // Only the low IDX_W address bits select a word, so addresses wrap mod MEM_DEPTH.
    localparam int IDX_W = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_PEND = 2'd1,
        F_DONE = 2'd2
    } fstate_e;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    fstate_e               fstate_q, fstate_d;
    logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
    logic [DATA_WIDTH-1:0] exec_rd_data_q;
    logic [DATA_WIDTH-1:0] ifu_rd_data_q;
    logic                  proto_err_q, proto_err_d;

    logic                  bus_busy;
    logic                  rd_gnt;
    logic                  fetch_new;
    logic                  fetch_want;
    logic                  fetch_gnt;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;

    // Arbitration for the single array port and address/data steering.
    always_comb begin
        bus_busy   = ld_en | exec_wr_req | exec_rd_req;
        wr_en      = ld_en | exec_wr_req;
        wr_addr    = ld_en ? ld_addr : exec_wr_addr;
        wr_data    = ld_en ? ld_data : exec_wr_data;
        // A colliding write or preload wins; the exec read is simply dropped.
        rd_gnt     = exec_rd_req & ~exec_wr_req & ~ld_en;
        // In F_DONE a new request is accepted just as in F_IDLE (back-to-back fetch).
        fetch_new  = ifu_rd_req & (fstate_q != F_PEND);
        fetch_want = fetch_new | (fstate_q == F_PEND);
        fetch_addr = fetch_new ? ifu_rd_addr : faddr_q;
        fetch_gnt  = fetch_want & ~bus_busy;
        rd_addr    = rd_gnt ? exec_rd_addr : fetch_addr;
    end

    // Fetch FSM next state, captured fetch address and sticky error flag.
    always_comb begin
        fstate_d    = fstate_q;
        faddr_d     = faddr_q;
        proto_err_d = proto_err_q;

        if (exec_rd_req && exec_wr_req) begin
            proto_err_d = 1'b1;
        end
        if (ld_en && (exec_rd_req || exec_wr_req)) begin
            proto_err_d = 1'b1;
        end

        unique case (fstate_q)
            F_IDLE, F_DONE: begin
                if (ifu_rd_req) begin
                    faddr_d  = ifu_rd_addr;
                    fstate_d = fetch_gnt ? F_DONE : F_PEND;
                end else begin
                    fstate_d = F_IDLE;
                end
            end
            F_PEND: begin
                // A second fetch request while one is outstanding is not queued.
                if (ifu_rd_req) begin
                    proto_err_d = 1'b1;
                end
                if (fetch_gnt) begin
                    fstate_d = F_DONE;
                end
            end
            default: fstate_d = F_IDLE;
        endcase
    end

    // Main store write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    // Control state and registered read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fstate_q       <= F_IDLE;
            faddr_q        <= '0;
            proto_err_q    <= 1'b0;
            exec_rd_data_q <= '0;
            ifu_rd_data_q  <= '0;
        end else begin
            fstate_q    <= fstate_d;
            faddr_q     <= faddr_d;
            proto_err_q <= proto_err_d;
            if (rd_gnt) begin
                exec_rd_data_q <= mem_q[rd_addr[IDX_W-1:0]];
            end
            if (fetch_gnt) begin
                ifu_rd_data_q <= mem_q[rd_addr[IDX_W-1:0]];
            end
        end
    end

    assign exec_rd_data = exec_rd_data_q;
    assign ifu_rd_data  = ifu_rd_data_q;
    assign ifu_rd_valid = (fstate_q == F_DONE);
    assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_pdp_mem_responder.sv
// tb_pdp_mem_responder: directed scenarios followed by randomized traffic,
// every cycle compared against a request-level reference model.
module tb_pdp_mem_responder;

    localparam int AW = 12;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          exec_rd_req;
    logic [AW-1:0] exec_rd_addr;
    logic [DW-1:0] exec_rd_data;
    logic          exec_wr_req;
    logic [AW-1:0] exec_wr_addr;
    logic [DW-1:0] exec_wr_data;
    logic          ifu_rd_req;
    logic [AW-1:0] ifu_rd_addr;
    logic [DW-1:0] ifu_rd_data;
    logic          ifu_rd_valid;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          proto_err;

    always #5 clk = ~clk;

    pdp_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(4096)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .exec_rd_req  (exec_rd_req),
        .exec_rd_addr (exec_rd_addr),
        .exec_rd_data (exec_rd_data),
        .exec_wr_req  (exec_wr_req),
        .exec_wr_addr (exec_wr_addr),
        .exec_wr_data (exec_wr_data),
        .ifu_rd_req   (ifu_rd_req),
        .ifu_rd_addr  (ifu_rd_addr),
        .ifu_rd_data  (ifu_rd_data),
        .ifu_rd_valid (ifu_rd_valid),
        .ld_en        (ld_en),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .proto_err    (proto_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: memory image, last exec read, outstanding fetch, last fetch result.
    logic [DW-1:0] m_mem [4096];
    logic [DW-1:0] m_rd;
    logic [DW-1:0] m_ifu;
    logic          m_valid;
    logic          m_err;
    logic          m_pend;
    logic [AW-1:0] m_faddr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_rd_data"}, exec_rd_data, m_rd);
        chk({tag, "_ifu_valid"}, ifu_rd_valid, m_valid);
        chk({tag, "_ifu_data"}, ifu_rd_data, m_ifu);
        chk({tag, "_proto_err"}, proto_err, m_err);
    endtask

    task automatic idle();
        exec_rd_req  = 1'b0;
        exec_wr_req  = 1'b0;
        ifu_rd_req   = 1'b0;
        ld_en        = 1'b0;
    endtask

    task automatic model_reset();
        m_rd    = '0;
        m_ifu   = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_pend  = 1'b0;
    endtask

    // Effect of the coming clock edge given the inputs currently driven.
    task automatic model_edge();
        logic busy;
        if (exec_rd_req && exec_wr_req) m_err = 1'b1;
        if (ld_en && (exec_rd_req || exec_wr_req)) m_err = 1'b1;
        if (ifu_rd_req && m_pend) m_err = 1'b1;
        busy = ld_en || exec_wr_req || exec_rd_req;
        if (!m_pend && ifu_rd_req) begin
            m_pend  = 1'b1;
            m_faddr = ifu_rd_addr;
        end
        m_valid = 1'b0;
        if (m_pend && !busy) begin
            m_ifu   = m_mem[m_faddr];
            m_valid = 1'b1;
            m_pend  = 1'b0;
        end
        if (exec_rd_req && !exec_wr_req && !ld_en) m_rd = m_mem[exec_rd_addr];
        if (ld_en) m_mem[ld_addr] = ld_data;
        else if (exec_wr_req) m_mem[exec_wr_addr] = exec_wr_data;
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    // Called 1 time unit after an edge; asserts reset mid-cycle, checks the
    // asynchronous clear, holds across one edge and releases mid-cycle.
    task automatic do_reset(input string tag);
        idle();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk({tag, "_rd_data"}, exec_rd_data, 0);
        chk({tag, "_ifu_valid"}, ifu_rd_valid, 0);
        chk({tag, "_ifu_data"}, ifu_rd_data, 0);
        chk({tag, "_proto_err"}, proto_err, 0);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
    endtask

    function automatic logic [AW-1:0] pool_addr(input int idx);
        logic [AW-1:0] a;
        if (idx < 8) a = AW'(idx);
        else a = 12'o7770 + AW'(idx - 8);
        return a;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        exec_rd_addr = '0;
        exec_wr_addr = '0;
        exec_wr_data = '0;
        ifu_rd_addr  = '0;
        ld_addr      = '0;
        ld_data      = '0;
        m_faddr      = '0;
        reset_n      = 1'b0;
        model_reset();
        #1;
        chk_all("reset");
        @(posedge clk);
        #3;
        reset_n = 1'b1;

        // T1: preload then exec read
        ld_en = 1'b1; ld_addr = 12'o200; ld_data = 12'o1234;
        cycle("t1_ld0");
        ld_addr = 12'o201; ld_data = 12'o4321;
        cycle("t1_ld1");
        idle();
        exec_rd_req = 1'b1; exec_rd_addr = 12'o200;
        cycle("t1_rd");
        chk("t1_rd_lit", exec_rd_data, 12'o1234);
        idle();
        cycle("t1_hold");
        chk("t1_hold_lit", exec_rd_data, 12'o1234);

        // T2: held write, then read back
        exec_wr_req = 1'b1; exec_wr_addr = 12'o300; exec_wr_data = 12'o7777;
        for (int i = 0; i < 3; i++) cycle("t2_wr");
        idle();
        exec_rd_req = 1'b1; exec_rd_addr = 12'o300;
        cycle("t2_rd");
        chk("t2_rd_lit", exec_rd_data, 12'o7777);
        chk("t2_err_lit", proto_err, 0);

        // T3: fetch blocked two cycles by an exec write
        idle();
        ifu_rd_req = 1'b1; ifu_rd_addr = 12'o200;
        exec_wr_req = 1'b1; exec_wr_addr = 12'o300; exec_wr_data = 12'o7777;
        cycle("t3_c1");
        chk("t3_c1_valid_lit", ifu_rd_valid, 0);
        ifu_rd_req = 1'b0;
        cycle("t3_c2");
        chk("t3_c2_valid_lit", ifu_rd_valid, 0);
        exec_wr_req = 1'b0;
        cycle("t3_c3");
        chk("t3_c3_valid_lit", ifu_rd_valid, 1);
        chk("t3_c3_data_lit", ifu_rd_data, 12'o1234);
        cycle("t3_after");
        chk("t3_after_valid_lit", ifu_rd_valid, 0);
        exec_rd_req = 1'b1; exec_rd_addr = 12'o300;
        cycle("t3_rd");
        chk("t3_rd_lit", exec_rd_data, 12'o7777);

        // T4: read and write collide at 0o10
        idle();
        exec_rd_req = 1'b1; exec_rd_addr = 12'o10;
        exec_wr_req = 1'b1; exec_wr_addr = 12'o10; exec_wr_data = 12'd5;
        cycle("t4_clash");
        chk("t4_rd_unchanged_lit", exec_rd_data, 12'o7777);
        chk("t4_err_lit", proto_err, 1);
        idle();
        exec_rd_req = 1'b1; exec_rd_addr = 12'o10;
        cycle("t4_rd");
        chk("t4_rd_lit", exec_rd_data, 12'd5);
        idle();
        cycle("t4_sticky");
        chk("t4_sticky_lit", proto_err, 1);
        do_reset("t4_rst");

        // T5: back-to-back fetches
        ifu_rd_req = 1'b1; ifu_rd_addr = 12'o200;
        cycle("t5_f0");
        chk("t5_f0_valid_lit", ifu_rd_valid, 1);
        chk("t5_f0_data_lit", ifu_rd_data, 12'o1234);
        ifu_rd_addr = 12'o201;
        cycle("t5_f1");
        chk("t5_f1_valid_lit", ifu_rd_valid, 1);
        chk("t5_f1_data_lit", ifu_rd_data, 12'o4321);
        idle();
        cycle("t5_end");
        chk("t5_end_valid_lit", ifu_rd_valid, 0);
        chk("t5_end_err_lit", proto_err, 0);

        // T6: reset while a fetch is pending
        ifu_rd_req = 1'b1; ifu_rd_addr = 12'o200;
        exec_wr_req = 1'b1; exec_wr_addr = 12'o300; exec_wr_data = 12'o7777;
        cycle("t6_pend");
        do_reset("t6_rst");
        for (int i = 0; i < 3; i++) begin
            cycle("t6_idle");
            chk("t6_idle_valid_lit", ifu_rd_valid, 0);
        end
        exec_rd_req = 1'b1; exec_rd_addr = 12'o200;
        cycle("t6_rd");
        chk("t6_rd_lit", exec_rd_data, 12'o1234);
        idle();

        // Randomized traffic over a small address pool spanning both ends of the store
        for (int i = 0; i < 16; i++) begin
            ld_en = 1'b1; ld_addr = pool_addr(i); ld_data = DW'($urandom);
            cycle("rnd_preload");
        end
        idle();
        do_reset("rnd_rst0");
        for (int n = 0; n < 300; n++) begin
            ld_en        = ($urandom % 8) == 0;
            ld_addr      = pool_addr(int'($urandom_range(0, 15)));
            ld_data      = DW'($urandom);
            exec_wr_req  = ($urandom % 4) == 0;
            exec_wr_addr = pool_addr(int'($urandom_range(0, 15)));
            exec_wr_data = DW'($urandom);
            exec_rd_req  = ($urandom % 3) == 0;
            exec_rd_addr = pool_addr(int'($urandom_range(0, 15)));
            ifu_rd_req   = ($urandom % 3) == 0;
            ifu_rd_addr  = pool_addr(int'($urandom_range(0, 15)));
            cycle("rnd");
            if ((n % 100) == 99) do_reset("rnd_rst");
        end
        idle();
        cycle("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
